// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and width-independent lane helpers
// shared by the load/store unit and its lane aligner.
package lsu_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_WORD_ALT = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    function automatic size_e norm_size(logic [1:0] s);
        return s == SZ_WORD_ALT ? SZ_WORD : size_e'(s);
    endfunction
    function automatic logic is_misaligned(size_e s, logic [1:0] a);
        return (s == SZ_HALF && a[0]) || (s == SZ_WORD && a != 2'b00);
    endfunction
    // Rounds the low address bits down to the natural boundary of the access.
    function automatic logic [1:0] align_low(size_e s, logic [1:0] a);
        return s == SZ_BYTE ? a : s == SZ_HALF ? {a[1], 1'b0} : 2'b00;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response and data-memory signals of the LSU.
// master = CPU + memory side, slave = the load/store unit.
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);
    logic                  req_valid;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  busy;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  misalign_err;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  busy, rdata, rdata_valid, misalign_err, mem_addr, mem_wdata, mem_write, mem_read
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output busy, rdata, rdata_valid, misalign_err, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction with sign/zero extension for
// loads, and byte-lane merge of right-aligned store data into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
#(parameter int DATA_WIDTH = 32) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            lane_i,
    input  size_e                 size_i,
    input  logic                  unsigned_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic [DATA_WIDTH-1:0] store_o
);
    logic [4:0]            sh;
    logic [BYTE_W-1:0]     b;
    logic [HALF_W-1:0]     h;
    logic [DATA_WIDTH-1:0] mask;
    always_comb begin
        sh = size_i == SZ_BYTE ? {lane_i, 3'b000} : size_i == SZ_HALF ? {lane_i[1], 4'b0000} : 5'd0;
        b = BYTE_W'(word_i >> sh);
        h = HALF_W'(word_i >> sh);
        mask = size_i == SZ_BYTE ? DATA_WIDTH'({BYTE_W{1'b1}}) << sh :
               size_i == SZ_HALF ? DATA_WIDTH'({HALF_W{1'b1}}) << sh : '1;
        load_o = size_i == SZ_BYTE ? {{(DATA_WIDTH-BYTE_W){~unsigned_i & b[BYTE_W-1]}}, b} :
                 size_i == SZ_HALF ? {{(DATA_WIDTH-HALF_W){~unsigned_i & h[HALF_W-1]}}, h} : word_i;
        store_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store FSM with read-modify-write
// for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(parameter int DATA_WIDTH = 32) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    state_e                state_q, state_d;
    size_e                 size_q, size_d;
    logic                  write_q, write_d, unsigned_q, unsigned_d, trap;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] load_data, store_word;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
    assign trap = is_misaligned(norm_size(bus.req_size), bus.req_addr[1:0]);
    assign bus.misalign_err = state_q == RESP && misalign_q;
`else
    assign trap = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif
    // READ extracts straight from the memory port; WRITE merges into the captured word.
    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word_i    (state_q == READ ? bus.mem_rdata : word_q),
        .lane_i    (addr_q[1:0]),
        .size_i    (size_q),
        .unsigned_i(unsigned_q),
        .wdata_i   (wdata_q),
        .load_o    (load_data),
        .store_o   (store_word)
    );
    always_comb begin
        state_d = state_q;
        size_d = size_q;
        write_d = write_q;
        unsigned_d = unsigned_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        word_d = word_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                size_d = norm_size(bus.req_size);
                write_d = bus.req_write;
                unsigned_d = bus.req_unsigned;
                addr_d = {bus.req_addr[DATA_WIDTH-1:2], align_low(size_d, bus.req_addr[1:0])};
                wdata_d = bus.req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_d = trap;
`endif
                rdata_d = trap ? '0 : rdata_q;
                state_d = trap ? RESP : (bus.req_write && size_d == SZ_WORD) ? WRITE : READ;
            end
            READ: begin
                word_d = bus.mem_rdata;
                rdata_d = write_q ? rdata_q : load_data;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE: begin
                rdata_d = '0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            size_q <= SZ_BYTE;
            write_q <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            word_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            size_q <= size_d;
            write_q <= write_d;
            unsigned_q <= unsigned_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            word_q <= word_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.rdata = rdata_q;
    assign bus.rdata_valid = state_q == RESP;
    assign bus.mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = state_q == WRITE ? store_word : '0;
    assign bus.mem_write = state_q == WRITE;
    assign bus.mem_read = state_q == READ;
endmodule
